// File: rtl/combo_lock_pkg.sv
// Shared types and constants for the combination-lock controller and its display path.
package combo_lock_pkg;

  localparam int DIGIT_W_DEF    = 4;
  localparam int NUM_DIGITS_DEF = 6;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_ERROR   = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_PROG    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    MSG_CLOSED = 3'd0,
    MSG_OPEN   = 3'd1,
    MSG_ERROR  = 3'd2,
    MSG_LOC    = 3'd3,
    MSG_PROG   = 3'd4
  } hex_msg_t;

  // Message the HEX driver renders for a given controller state.
  function automatic hex_msg_t state_to_msg(input state_t s);
    hex_msg_t m;
    case (s)
      ST_ENTRY:   m = MSG_CLOSED;
      ST_OPEN:    m = MSG_OPEN;
      ST_ERROR:   m = MSG_ERROR;
      ST_LOCKOUT: m = MSG_LOC;
      ST_PROG:    m = MSG_PROG;
      default:    m = MSG_CLOSED;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/combo_lock_ctrl_lockout_timer.sv
// Loadable down-counter that times the lockout period and flags its final clock.
module lockout_timer #(
  parameter int CYCLES = 16,
  parameter int W      = $clog2(CYCLES + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_clr,
  output logic [W-1:0] o_left,
  output logic         o_done
);

  logic [W-1:0] r_left;

  // Load has priority so the counter can start on the same edge the FSM enters lockout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left <= {W{1'b0}};
    end else if (i_load) begin
      r_left <= W'(CYCLES);
    end else if (i_clr) begin
      r_left <= {W{1'b0}};
    end else if (r_left != {W{1'b0}}) begin
      r_left <= r_left - W'(1);
    end else begin
      r_left <= r_left;
    end
  end

  assign o_left = r_left;
  assign o_done = (r_left == W'(1));

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination-lock sequencer: digit entry and compare, fail counting, timed lockout, reprogramming.
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int                              NUM_DIGITS     = NUM_DIGITS_DEF,
  parameter int                              DIGIT_W        = DIGIT_W_DEF,
  parameter int                              MAX_FAILS      = 3,
  parameter int                              LOCKOUT_CYCLES = 16,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]   DEFAULT_COMBO  = 24'h838482,
  localparam int                             LO_W           = $clog2(LOCKOUT_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               digit_valid,
  input  logic               relock,
  input  logic               prog_req,
  output logic [2:0]         state_code,
  output logic [2:0]         digit_count,
  output logic [2:0]         fail_count,
  output logic [LO_W-1:0]    lockout_left,
  output logic               closed_n
);

  localparam int         COMBO_W = NUM_DIGITS * DIGIT_W;
  localparam logic [2:0] LAST    = 3'(NUM_DIGITS - 1);

  state_t               r_state;
  logic [2:0]           r_digit_cnt;
  logic [2:0]           r_fail;
  logic                 r_mismatch;
  logic                 r_closed_n;
  logic [COMBO_W-1:0]   r_combo;
  logic [COMBO_W-1:0]   r_shadow;

  state_t               w_state_nxt;
  logic [2:0]           w_cnt_nxt;
  logic [2:0]           w_fail_nxt;
  logic                 w_mis_nxt;
  logic [COMBO_W-1:0]   w_combo_nxt;
  logic [COMBO_W-1:0]   w_shadow_nxt;
  logic [COMBO_W-1:0]   w_shift;
  logic                 w_tmr_load;
  logic                 w_tmr_clr;
  logic                 w_tmr_done;
  logic [LO_W-1:0]      w_tmr_left;
  logic                 w_mis_final;

  function automatic logic [DIGIT_W-1:0] combo_digit(input logic [COMBO_W-1:0] combo,
                                                     input logic [2:0]         idx);
    logic [COMBO_W-1:0] sh;
    sh = combo >> (32'(idx) * DIGIT_W);
    return sh[DIGIT_W-1:0];
  endfunction

  // First digit entered is the most significant nibble of the stored combination.
  assign w_mis_final = r_mismatch | (digit_in != combo_digit(r_combo, LAST - r_digit_cnt));
  assign w_shift     = {r_shadow[COMBO_W-DIGIT_W-1:0], digit_in};
  assign w_tmr_clr   = (r_state != ST_LOCKOUT);

  lockout_timer #(
    .CYCLES (LOCKOUT_CYCLES),
    .W      (LO_W)
  ) u_lockout_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_tmr_load),
    .i_clr  (w_tmr_clr),
    .o_left (w_tmr_left),
    .o_done (w_tmr_done)
  );

  // Next-state and datapath update decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_digit_cnt;
    w_fail_nxt   = r_fail;
    w_mis_nxt    = r_mismatch;
    w_combo_nxt  = r_combo;
    w_shadow_nxt = r_shadow;
    w_tmr_load   = 1'b0;
    case (r_state)
      ST_ENTRY: begin
        if (digit_valid) begin
          if (r_digit_cnt == LAST) begin
            w_cnt_nxt = 3'd0;
            w_mis_nxt = 1'b0;
            if (!w_mis_final) begin
              w_state_nxt = ST_OPEN;
              w_fail_nxt  = 3'd0;
            end else if (({1'b0, r_fail} + 4'd1) < 4'(MAX_FAILS)) begin
              w_state_nxt = ST_ERROR;
              w_fail_nxt  = r_fail + 3'd1;
            end else begin
              w_state_nxt = ST_LOCKOUT;
              w_tmr_load  = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_digit_cnt + 3'd1;
            w_mis_nxt = w_mis_final;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_OPEN: begin
        if (prog_req) begin
          w_state_nxt = ST_PROG;
          w_cnt_nxt   = 3'd0;
        end else if (relock) begin
          w_state_nxt = ST_ENTRY;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_ERROR: begin
        if (relock) begin
          w_state_nxt = ST_ENTRY;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_LOCKOUT: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_ENTRY;
          w_fail_nxt  = 3'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_PROG: begin
        if (relock) begin
          w_state_nxt = ST_ENTRY;
          w_cnt_nxt   = 3'd0;
        end else if (digit_valid) begin
          w_shadow_nxt = w_shift;
          if (r_digit_cnt == LAST) begin
            w_combo_nxt = w_shift;
            w_state_nxt = ST_OPEN;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_cnt_nxt = r_digit_cnt + 3'd1;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_ENTRY;
        w_cnt_nxt   = 3'd0;
        w_mis_nxt   = 1'b0;
        w_fail_nxt  = 3'd0;
      end
    endcase
  end

  // Controller state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ENTRY;
      r_digit_cnt <= 3'd0;
      r_fail      <= 3'd0;
      r_mismatch  <= 1'b0;
      r_closed_n  <= 1'b0;
      r_combo     <= DEFAULT_COMBO;
      r_shadow    <= {COMBO_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_digit_cnt <= w_cnt_nxt;
      r_fail      <= w_fail_nxt;
      r_mismatch  <= w_mis_nxt;
      r_closed_n  <= (w_state_nxt == ST_OPEN);
      r_combo     <= w_combo_nxt;
      r_shadow    <= w_shadow_nxt;
    end
  end

  assign state_code   = r_state;
  assign digit_count  = r_digit_cnt;
  assign fail_count   = r_fail;
  assign lockout_left = w_tmr_left;
  assign closed_n     = r_closed_n;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Scoreboard bench for combo_lock_ctrl: stimulus steps queue their expected outputs, popped after each edge.
module tb_combo_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       digit_valid = 1'b0;
  logic       relock = 1'b0;
  logic       prog_req = 1'b0;
  logic [2:0] state_code;
  logic [2:0] digit_count;
  logic [2:0] fail_count;
  logic [4:0] lockout_left;
  logic       closed_n;

  combo_lock_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .digit_in     (digit_in),
    .digit_valid  (digit_valid),
    .relock       (relock),
    .prog_req     (prog_req),
    .state_code   (state_code),
    .digit_count  (digit_count),
    .fail_count   (fail_count),
    .lockout_left (lockout_left),
    .closed_n     (closed_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [3:0]  d;
    logic        rl;
    logic        pr;
    logic [14:0] exp;
    logic [14:0] mask;
  } stim_t;

  localparam logic [14:0] FULL   = 15'h7fff;
  localparam logic [14:0] NOFAIL = 15'h7e3f;

  stim_t stim[$];
  stim_t sb[$];
  int    checks = 0;
  int    passes = 0;

  // Observation layout: {state, digit_count, fail_count, lockout_left, closed_n}
  function automatic logic [14:0] ex(input logic [2:0] s, input logic [2:0] c, input logic [2:0] f,
                                     input logic [4:0] l, input logic cl);
    return {s, c, f, l, cl};
  endfunction

  function automatic logic [14:0] obs();
    return {state_code, digit_count, fail_count, lockout_left, closed_n};
  endfunction

  task automatic add_step(input logic v, input logic [3:0] d, input logic rl, input logic pr,
                          input logic [14:0] e, input logic [14:0] m);
    stim_t t;
    t = '{v: v, d: d, rl: rl, pr: pr, exp: e, mask: m};
    stim.push_back(t);
  endtask

  task automatic add_entry(input logic [23:0] seq, input logic [2:0] st, input logic [2:0] fail,
                           input logic [14:0] fin, input logic [14:0] fmask);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) add_step(1'b1, seq[23-4*i -: 4], 1'b0, 1'b0, fin, fmask);
      else        add_step(1'b1, seq[23-4*i -: 4], 1'b0, 1'b0, ex(st, 3'(i + 1), fail, 5'd0, 1'b0), FULL);
    end
  endtask

  task automatic test_reset();
    logic [14:0] got;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = obs();
    checks++;
    if (got !== 15'h0000) $display("FAIL reset_hold: got %h expected %h", got, 15'h0000);
    else passes++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    got = obs();
    checks++;
    if (got !== ex(3'd0, 3'd0, 3'd0, 5'd0, 1'b0)) $display("FAIL reset_release: got %h expected %h", got, 15'h0000);
    else passes++;
  endtask

  task automatic test_open();
    stim_t t, e;
    logic [14:0] got;
    int n = 0;
    add_entry(24'h838482, 3'd0, 3'd0, ex(3'd1, 3'd0, 3'd0, 5'd0, 1'b1), FULL);
    add_step(1'b1, 4'h5, 1'b0, 1'b0, ex(3'd1, 3'd0, 3'd0, 5'd0, 1'b1), FULL);
    add_step(1'b0, 4'h0, 1'b1, 1'b0, ex(3'd0, 3'd0, 3'd0, 5'd0, 1'b0), FULL);
    while (stim.size() > 0) begin
      t = stim.pop_front();
      digit_valid = t.v; digit_in = t.d; relock = t.rl; prog_req = t.pr;
      sb.push_back(t);
      @(posedge clk); #1;
      digit_valid = 1'b0; relock = 1'b0; prog_req = 1'b0;
      e = sb.pop_front(); got = obs(); checks++;
      if ((got & e.mask) !== (e.exp & e.mask)) $display("FAIL open step%0d: got %h expected %h", n, got, e.exp);
      else passes++;
      n++;
    end
  endtask

  task automatic test_error();
    stim_t t, e;
    logic [14:0] got;
    int n = 0;
    add_entry(24'h838982, 3'd0, 3'd0, ex(3'd2, 3'd0, 3'd1, 5'd0, 1'b0), FULL);
    add_step(1'b1, 4'h8, 1'b0, 1'b0, ex(3'd2, 3'd0, 3'd1, 5'd0, 1'b0), FULL);
    add_step(1'b0, 4'h0, 1'b1, 1'b0, ex(3'd0, 3'd0, 3'd1, 5'd0, 1'b0), FULL);
    while (stim.size() > 0) begin
      t = stim.pop_front();
      digit_valid = t.v; digit_in = t.d; relock = t.rl; prog_req = t.pr;
      sb.push_back(t);
      @(posedge clk); #1;
      digit_valid = 1'b0; relock = 1'b0; prog_req = 1'b0;
      e = sb.pop_front(); got = obs(); checks++;
      if ((got & e.mask) !== (e.exp & e.mask)) $display("FAIL error step%0d: got %h expected %h", n, got, e.exp);
      else passes++;
      n++;
    end
  endtask

  task automatic test_lockout();
    stim_t t, e;
    logic [14:0] got;
    int n = 0;
    add_entry(24'h8384A2, 3'd0, 3'd1, ex(3'd2, 3'd0, 3'd2, 5'd0, 1'b0), FULL);
    add_step(1'b0, 4'h0, 1'b1, 1'b0, ex(3'd0, 3'd0, 3'd2, 5'd0, 1'b0), FULL);
    add_entry(24'h8384A2, 3'd0, 3'd2, ex(3'd3, 3'd0, 3'd0, 5'd16, 1'b0), NOFAIL);
    for (int k = 1; k <= 16; k++) begin
      if (k < 16) add_step(1'b1, 4'h8, 1'b1, 1'b1, ex(3'd3, 3'd0, 3'd0, 5'(16 - k), 1'b0), NOFAIL);
      else        add_step(1'b1, 4'h8, 1'b1, 1'b1, ex(3'd0, 3'd0, 3'd0, 5'd0, 1'b0), FULL);
    end
    add_entry(24'h838482, 3'd0, 3'd0, ex(3'd1, 3'd0, 3'd0, 5'd0, 1'b1), FULL);
    add_step(1'b0, 4'h0, 1'b1, 1'b0, ex(3'd0, 3'd0, 3'd0, 5'd0, 1'b0), FULL);
    while (stim.size() > 0) begin
      t = stim.pop_front();
      digit_valid = t.v; digit_in = t.d; relock = t.rl; prog_req = t.pr;
      sb.push_back(t);
      @(posedge clk); #1;
      digit_valid = 1'b0; relock = 1'b0; prog_req = 1'b0;
      e = sb.pop_front(); got = obs(); checks++;
      if ((got & e.mask) !== (e.exp & e.mask)) $display("FAIL lockout step%0d: got %h expected %h", n, got, e.exp);
      else passes++;
      n++;
    end
  endtask

  task automatic test_prog();
    stim_t t, e;
    logic [14:0] got;
    int n = 0;
    add_entry(24'h838482, 3'd0, 3'd0, ex(3'd1, 3'd0, 3'd0, 5'd0, 1'b1), FULL);
    add_step(1'b0, 4'h0, 1'b0, 1'b1, ex(3'd4, 3'd0, 3'd0, 5'd0, 1'b0), FULL);
    add_entry(24'h123456, 3'd4, 3'd0, ex(3'd1, 3'd0, 3'd0, 5'd0, 1'b1), FULL);
    add_step(1'b0, 4'h0, 1'b1, 1'b0, ex(3'd0, 3'd0, 3'd0, 5'd0, 1'b0), FULL);
    add_entry(24'h123456, 3'd0, 3'd0, ex(3'd1, 3'd0, 3'd0, 5'd0, 1'b1), FULL);
    add_step(1'b0, 4'h0, 1'b1, 1'b0, ex(3'd0, 3'd0, 3'd0, 5'd0, 1'b0), FULL);
    add_entry(24'h838482, 3'd0, 3'd0, ex(3'd2, 3'd0, 3'd1, 5'd0, 1'b0), FULL);
    add_step(1'b0, 4'h0, 1'b1, 1'b0, ex(3'd0, 3'd0, 3'd1, 5'd0, 1'b0), FULL);
    while (stim.size() > 0) begin
      t = stim.pop_front();
      digit_valid = t.v; digit_in = t.d; relock = t.rl; prog_req = t.pr;
      sb.push_back(t);
      @(posedge clk); #1;
      digit_valid = 1'b0; relock = 1'b0; prog_req = 1'b0;
      e = sb.pop_front(); got = obs(); checks++;
      if ((got & e.mask) !== (e.exp & e.mask)) $display("FAIL prog step%0d: got %h expected %h", n, got, e.exp);
      else passes++;
      n++;
    end
  endtask

  task automatic test_gaps_and_reset();
    stim_t t, e;
    logic [14:0] got;
    int n = 0;
    add_step(1'b1, 4'h8, 1'b0, 1'b0, ex(3'd0, 3'd1, 3'd1, 5'd0, 1'b0), FULL);
    add_step(1'b0, 4'h3, 1'b0, 1'b0, ex(3'd0, 3'd1, 3'd1, 5'd0, 1'b0), FULL);
    add_step(1'b0, 4'h3, 1'b0, 1'b0, ex(3'd0, 3'd1, 3'd1, 5'd0, 1'b0), FULL);
    add_step(1'b1, 4'h3, 1'b0, 1'b0, ex(3'd0, 3'd2, 3'd1, 5'd0, 1'b0), FULL);
    add_step(1'b0, 4'h8, 1'b0, 1'b0, ex(3'd0, 3'd2, 3'd1, 5'd0, 1'b0), FULL);
    add_step(1'b0, 4'h8, 1'b0, 1'b0, ex(3'd0, 3'd2, 3'd1, 5'd0, 1'b0), FULL);
    add_step(1'b1, 4'h8, 1'b0, 1'b0, ex(3'd0, 3'd3, 3'd1, 5'd0, 1'b0), FULL);
    while (stim.size() > 0) begin
      t = stim.pop_front();
      digit_valid = t.v; digit_in = t.d; relock = t.rl; prog_req = t.pr;
      sb.push_back(t);
      @(posedge clk); #1;
      digit_valid = 1'b0; relock = 1'b0; prog_req = 1'b0;
      e = sb.pop_front(); got = obs(); checks++;
      if ((got & e.mask) !== (e.exp & e.mask)) $display("FAIL gaps step%0d: got %h expected %h", n, got, e.exp);
      else passes++;
      n++;
    end
    #2 rst_n = 1'b0;
    #1 got = obs();
    checks++;
    if (got !== 15'h0000) $display("FAIL async_reset: got %h expected %h", got, 15'h0000);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    add_entry(24'h838482, 3'd0, 3'd0, ex(3'd1, 3'd0, 3'd0, 5'd0, 1'b1), FULL);
    add_step(1'b0, 4'h0, 1'b1, 1'b0, ex(3'd0, 3'd0, 3'd0, 5'd0, 1'b0), FULL);
    while (stim.size() > 0) begin
      t = stim.pop_front();
      digit_valid = t.v; digit_in = t.d; relock = t.rl; prog_req = t.pr;
      sb.push_back(t);
      @(posedge clk); #1;
      digit_valid = 1'b0; relock = 1'b0; prog_req = 1'b0;
      e = sb.pop_front(); got = obs(); checks++;
      if ((got & e.mask) !== (e.exp & e.mask)) $display("FAIL post_reset step%0d: got %h expected %h", n, got, e.exp);
      else passes++;
      n++;
    end
  endtask

  task automatic test_prog_abort();
    stim_t t, e;
    logic [14:0] got;
    int n = 0;
    add_entry(24'h838482, 3'd0, 3'd0, ex(3'd1, 3'd0, 3'd0, 5'd0, 1'b1), FULL);
    add_step(1'b0, 4'h0, 1'b0, 1'b1, ex(3'd4, 3'd0, 3'd0, 5'd0, 1'b0), FULL);
    add_step(1'b1, 4'h1, 1'b0, 1'b0, ex(3'd4, 3'd1, 3'd0, 5'd0, 1'b0), FULL);
    add_step(1'b1, 4'h2, 1'b0, 1'b0, ex(3'd4, 3'd2, 3'd0, 5'd0, 1'b0), FULL);
    add_step(1'b1, 4'h3, 1'b0, 1'b0, ex(3'd4, 3'd3, 3'd0, 5'd0, 1'b0), FULL);
    add_step(1'b0, 4'h0, 1'b1, 1'b0, ex(3'd0, 3'd0, 3'd0, 5'd0, 1'b0), FULL);
    add_entry(24'h838482, 3'd0, 3'd0, ex(3'd1, 3'd0, 3'd0, 5'd0, 1'b1), FULL);
    add_step(1'b0, 4'h0, 1'b1, 1'b0, ex(3'd0, 3'd0, 3'd0, 5'd0, 1'b0), FULL);
    while (stim.size() > 0) begin
      t = stim.pop_front();
      digit_valid = t.v; digit_in = t.d; relock = t.rl; prog_req = t.pr;
      sb.push_back(t);
      @(posedge clk); #1;
      digit_valid = 1'b0; relock = 1'b0; prog_req = 1'b0;
      e = sb.pop_front(); got = obs(); checks++;
      if ((got & e.mask) !== (e.exp & e.mask)) $display("FAIL prog_abort step%0d: got %h expected %h", n, got, e.exp);
      else passes++;
      n++;
    end
  endtask

  task automatic test_back_to_back();
    stim_t t, e;
    logic [14:0] got;
    int n = 0;
    add_entry(24'h838482, 3'd0, 3'd0, ex(3'd1, 3'd0, 3'd0, 5'd0, 1'b1), FULL);
    add_step(1'b0, 4'h0, 1'b1, 1'b1, ex(3'd4, 3'd0, 3'd0, 5'd0, 1'b0), FULL);
    add_step(1'b0, 4'h0, 1'b1, 1'b0, ex(3'd0, 3'd0, 3'd0, 5'd0, 1'b0), FULL);
    add_entry(24'h838982, 3'd0, 3'd0, ex(3'd2, 3'd0, 3'd1, 5'd0, 1'b0), FULL);
    add_step(1'b0, 4'h0, 1'b1, 1'b0, ex(3'd0, 3'd0, 3'd1, 5'd0, 1'b0), FULL);
    add_entry(24'h838482, 3'd0, 3'd1, ex(3'd1, 3'd0, 3'd0, 5'd0, 1'b1), FULL);
    add_step(1'b0, 4'h0, 1'b1, 1'b0, ex(3'd0, 3'd0, 3'd0, 5'd0, 1'b0), FULL);
    while (stim.size() > 0) begin
      t = stim.pop_front();
      digit_valid = t.v; digit_in = t.d; relock = t.rl; prog_req = t.pr;
      sb.push_back(t);
      @(posedge clk); #1;
      digit_valid = 1'b0; relock = 1'b0; prog_req = 1'b0;
      e = sb.pop_front(); got = obs(); checks++;
      if ((got & e.mask) !== (e.exp & e.mask)) $display("FAIL back_to_back step%0d: got %h expected %h", n, got, e.exp);
      else passes++;
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_open();
    test_error();
    test_lockout();
    test_prog();
    test_gaps_and_reset();
    test_prog_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
